// File: rtl/dcdir_assoc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcdir_assoc_pkg
// Purpose  : Shared definitions for the set-associative D-cache directory:
//            sweep FSM state encodings and the tree-PLRU bit count helper.
// Ports    : none (package)
// Options  : none here; the DCDIR_PARITY_EN option lives in dcdir_assoc.
// Revision : 1.0 - initial N-way release
// ============================================================================
package dcdir_assoc_pkg;

    // Sweep FSM encodings
    localparam logic [0:0] DCDIR_IDLE  = 1'b0;
    localparam logic [0:0] DCDIR_FLUSH = 1'b1;

    // A binary PLRU tree over WAYS leaves has WAYS-1 internal nodes. A
    // direct-mapped build keeps one dummy bit so no vector collapses to zero
    // width.
    function automatic int dcdir_plru_bits(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcdir_plru.sv
`default_nettype none
// ============================================================================
// Module   : dcdir_plru
// Purpose  : Combinational tree-PLRU helper for one set.
//            Node n (1-based heap order, stored at bit n-1) points at the
//            least recently used half of its subtree: 0 = left, 1 = right.
// Ports    : plru      - current tree bits of the set
//            inv_mask  - one bit per way, 1 = way holds no valid line
//            touch     - one-hot way to make MRU (lowest bit wins if several,
//                        all-zero leaves the tree unchanged)
//            victim    - one-hot replacement choice (lowest invalid way first)
//            plru_next - tree bits after touching 'touch'
// Revision : 1.0 - initial N-way release
// ============================================================================
module dcdir_plru
    import dcdir_assoc_pkg::*;
#(
    parameter int WAYS   = 4,
    parameter int PLRU_W = 3
) (
    input  logic [PLRU_W-1:0] plru,
    input  logic [WAYS-1:0]   inv_mask,
    input  logic [WAYS-1:0]   touch,
    output logic [WAYS-1:0]   victim,
    output logic [PLRU_W-1:0] plru_next
);

    localparam int LVLS = (WAYS > 1) ? $clog2(WAYS) : 1;

    generate
        if (WAYS == 1) begin : g_single
            logic w_unused;
            assign w_unused  = ^{plru, inv_mask, touch};
            assign victim    = 1'b1;
            assign plru_next = plru;
        end else begin : g_tree
            always_comb begin
                int   node;
                int   inv_way;
                int   t_way;
                int   vic_way;
                logic inv_any;
                logic t_any;

                // Lowest-index invalid way takes precedence over the tree.
                inv_any = 1'b0;
                inv_way = 0;
                for (int w = WAYS - 1; w >= 0; w--) begin
                    if (inv_mask[w]) begin
                        inv_any = 1'b1;
                        inv_way = w;
                    end
                end

                // Walk root to leaf following the LRU pointers; leaf heap
                // index minus WAYS is the way number.
                node = 1;
                for (int l = 0; l < LVLS; l++) begin
                    node = 2 * node + int'(plru[node - 1]);
                end
                vic_way = inv_any ? inv_way : (node - WAYS);

                victim          = '0;
                victim[vic_way] = 1'b1;

                t_any = 1'b0;
                t_way = 0;
                for (int w = WAYS - 1; w >= 0; w--) begin
                    if (touch[w]) begin
                        t_any = 1'b1;
                        t_way = w;
                    end
                end

                // Every node on the touched way's path points away from it.
                plru_next = plru;
                if (t_any) begin
                    for (int l = 0; l < LVLS; l++) begin
                        plru_next[((WAYS + t_way) >> (LVLS - l)) - 1] =
                            (((t_way >> (LVLS - 1 - l)) & 1) == 0);
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/dcdir_assoc.sv
`default_nettype none
// ============================================================================
// Module   : dcdir_assoc
// Purpose  : N-way set-associative data-cache directory. Per-way tag+valid,
//            per-set tree-PLRU, registered one-cycle lookup with hit/victim,
//            fill/invalidate writes and an invalidate-all sweep FSM.
// Ports    : clk, rst_n (synchronous, active low)
//            lk_val/lk_idx/lk_tag/lk_rdy          - lookup request
//            rs_val/rs_hit/rs_way/rs_victim       - lookup result (cycle+1)
//            wr_val/wr_idx/wr_way/wr_tag/wr_vld   - fill (1) / invalidate (0)
//            inv_all/flush_busy                   - invalidate-all sweep
//            perr                                 - lookup parity error
// Options  : DCDIR_PARITY_EN - adds per-entry even parity over {valid,tag}
//            and the perr output.
// Revision : 1.0 - initial N-way release
// ============================================================================
module dcdir_assoc
    import dcdir_assoc_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int SETS  = 128,
    parameter int TAG_W = 22,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lk_val,
    input  logic [IDX_W-1:0] lk_idx,
    input  logic [TAG_W-1:0] lk_tag,
    output logic             lk_rdy,
    output logic             rs_val,
    output logic             rs_hit,
    output logic [WAYS-1:0]  rs_way,
    output logic [WAYS-1:0]  rs_victim,
    input  logic             wr_val,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WAYS-1:0]  wr_way,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_vld,
    input  logic             inv_all,
    output logic             flush_busy
`ifdef DCDIR_PARITY_EN
    ,
    output logic             perr
`endif
);

    localparam int PLRU_W = dcdir_plru_bits(WAYS);

    // Directory storage
    logic [WAYS-1:0]   r_valid [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [PLRU_W-1:0] r_plru  [SETS];
`ifdef DCDIR_PARITY_EN
    logic [WAYS-1:0]   r_par   [SETS];
    logic [WAYS-1:0]   w_par_bad;
    logic              r_perr;
`endif

    // Sweep FSM
    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_flush_cnt;

    // Lookup result stage
    logic              r_rs_val;
    logic              r_rs_hit;
    logic [WAYS-1:0]   r_rs_way;
    logic [WAYS-1:0]   r_rs_victim;
    logic [IDX_W-1:0]  r_lk_idx;

    logic              w_idle;
    logic              w_lk_acc;
    logic              w_wr_en;
    logic [WAYS-1:0]   w_match;
    logic [WAYS-1:0]   w_lk_victim;
    logic [PLRU_W-1:0] w_lk_next_unused;
    logic [PLRU_W-1:0] w_hit_next;
    logic [WAYS-1:0]   w_hit_victim_unused;
    logic [PLRU_W-1:0] w_wr_next;
    logic [WAYS-1:0]   w_wr_victim_unused;

    assign w_idle   = (r_state == DCDIR_IDLE);
    assign w_lk_acc = lk_val & w_idle;
    assign w_wr_en  = wr_val & w_idle;

    // Tag compare against the pre-write contents of the indexed set.
    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_way
`ifdef DCDIR_PARITY_EN
            // Only valid entries are checked: reset and the sweep clear valid
            // without rewriting parity, so invalid entries may hold stale
            // parity. A corrupted way is forced to miss.
            assign w_par_bad[g] = r_valid[lk_idx][g] &
                                  (r_par[lk_idx][g] ^ (^{1'b1, r_tag[lk_idx][g]}));
            assign w_match[g]   = r_valid[lk_idx][g] & ~w_par_bad[g] &
                                  (r_tag[lk_idx][g] == lk_tag);
`else
            assign w_match[g]   = r_valid[lk_idx][g] & (r_tag[lk_idx][g] == lk_tag);
`endif
        end
    endgenerate

    // Victim choice from the set as read in the lookup cycle.
    dcdir_plru #(
        .WAYS   (WAYS),
        .PLRU_W (PLRU_W)
    ) u_plru_lk (
        .plru      (r_plru[lk_idx]),
        .inv_mask  (~r_valid[lk_idx]),
        .touch     ('0),
        .victim    (w_lk_victim),
        .plru_next (w_lk_next_unused)
    );

    // Hit promotion one cycle later, applied to the set's current tree so
    // that any update committed in between is not lost.
    dcdir_plru #(
        .WAYS   (WAYS),
        .PLRU_W (PLRU_W)
    ) u_plru_hit (
        .plru      (r_plru[r_lk_idx]),
        .inv_mask  ('0),
        .touch     (r_rs_way),
        .victim    (w_hit_victim_unused),
        .plru_next (w_hit_next)
    );

    // Fill promotion.
    dcdir_plru #(
        .WAYS   (WAYS),
        .PLRU_W (PLRU_W)
    ) u_plru_wr (
        .plru      (r_plru[wr_idx]),
        .inv_mask  ('0),
        .touch     (wr_way),
        .victim    (w_wr_victim_unused),
        .plru_next (w_wr_next)
    );

    // Valid bits, PLRU state and sweep FSM. Later assignments take priority:
    // hit promotion < fill promotion < sweep clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= DCDIR_IDLE;
            r_flush_cnt <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            if (r_rs_val && r_rs_hit) begin
                r_plru[r_lk_idx] <= w_hit_next;
            end
            if (r_state == DCDIR_IDLE) begin
                if (wr_val) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (wr_way[w]) begin
                            r_valid[wr_idx][w] <= wr_vld;
                        end
                    end
                    if (wr_vld && (|wr_way)) begin
                        r_plru[wr_idx] <= w_wr_next;
                    end
                end
                if (inv_all) begin
                    r_state     <= DCDIR_FLUSH;
                    r_flush_cnt <= '0;
                end
            end else begin
                r_valid[r_flush_cnt] <= '0;
                r_plru[r_flush_cnt]  <= '0;
                r_flush_cnt          <= r_flush_cnt + IDX_W'(1);
                if (r_flush_cnt == IDX_W'(SETS - 1)) begin
                    r_state <= DCDIR_IDLE;
                end
            end
        end
    end

    // Tags (and parity) carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (wr_way[w]) begin
                    if (wr_vld) begin
                        r_tag[wr_idx][w] <= wr_tag;
                    end
`ifdef DCDIR_PARITY_EN
                    r_par[wr_idx][w] <= wr_vld ? (^{1'b1, wr_tag})
                                               : (^{1'b0, r_tag[wr_idx][w]});
`endif
                end
            end
        end
    end

    // Registered lookup result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rs_val    <= 1'b0;
            r_rs_hit    <= 1'b0;
            r_rs_way    <= '0;
            r_rs_victim <= '0;
            r_lk_idx    <= '0;
`ifdef DCDIR_PARITY_EN
            r_perr      <= 1'b0;
`endif
        end else begin
            r_rs_val <= w_lk_acc;
`ifdef DCDIR_PARITY_EN
            r_perr   <= w_lk_acc & (|w_par_bad);
`endif
            if (w_lk_acc) begin
                r_rs_hit    <= |w_match;
                r_rs_way    <= w_match;
                r_rs_victim <= w_lk_victim;
                r_lk_idx    <= lk_idx;
            end
        end
    end

    assign lk_rdy     = w_idle;
    assign flush_busy = ~w_idle;
    assign rs_val     = r_rs_val;
    assign rs_hit     = r_rs_hit;
    assign rs_way     = r_rs_way;
    assign rs_victim  = r_rs_victim;
`ifdef DCDIR_PARITY_EN
    assign perr       = r_perr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcdir_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcdir_assoc
// Purpose  : Self-checking bench for dcdir_assoc. A behavioural directory
//            model (arrays of valid/tag plus a PLRU tree walked by range
//            bisection) predicts every lookup result and the sweep status.
// Revision : 1.0 - initial N-way release
// ============================================================================
module tb_dcdir_assoc;

    localparam int WAYS  = 4;
    localparam int SETS  = 128;
    localparam int TAG_W = 22;
    localparam int IDX_W = $clog2(SETS);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             lk_val = 1'b0;
    logic [IDX_W-1:0] lk_idx = '0;
    logic [TAG_W-1:0] lk_tag = '0;
    logic             lk_rdy;
    logic             rs_val;
    logic             rs_hit;
    logic [WAYS-1:0]  rs_way;
    logic [WAYS-1:0]  rs_victim;
    logic             wr_val = 1'b0;
    logic [IDX_W-1:0] wr_idx = '0;
    logic [WAYS-1:0]  wr_way = '0;
    logic [TAG_W-1:0] wr_tag = '0;
    logic             wr_vld = 1'b0;
    logic             inv_all = 1'b0;
    logic             flush_busy;
`ifdef DCDIR_PARITY_EN
    logic             perr;
`endif

    always #5 clk = ~clk;

    dcdir_assoc #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lk_val     (lk_val),
        .lk_idx     (lk_idx),
        .lk_tag     (lk_tag),
        .lk_rdy     (lk_rdy),
        .rs_val     (rs_val),
        .rs_hit     (rs_hit),
        .rs_way     (rs_way),
        .rs_victim  (rs_victim),
        .wr_val     (wr_val),
        .wr_idx     (wr_idx),
        .wr_way     (wr_way),
        .wr_tag     (wr_tag),
        .wr_vld     (wr_vld),
        .inv_all    (inv_all),
        .flush_busy (flush_busy)
`ifdef DCDIR_PARITY_EN
        ,
        .perr       (perr)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    bit             m_valid [SETS][WAYS];
    bit [TAG_W-1:0] m_tag   [SETS][WAYS];
    bit             m_node  [SETS][WAYS];   // tree nodes 1..WAYS-1, 1 = LRU on right
    bit             m_bad   [SETS][WAYS];   // corrupted parity
    bit             m_busy;
    int             m_cnt;
    bit             p_hit;
    int             p_idx;
    int             p_way;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_victim(input int s);
        int lo;
        int size;
        int n;
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
        lo = 0; size = WAYS; n = 1;
        while (size > 1) begin
            size = size / 2;
            if (m_node[s][n]) begin lo = lo + size; n = 2 * n + 1; end
            else n = 2 * n;
        end
        return lo;
    endfunction

    task automatic m_touch(input int s, input int w);
        int lo;
        int size;
        int n;
        lo = 0; size = WAYS; n = 1;
        while (size > 1) begin
            size = size / 2;
            if (w < lo + size) begin m_node[s][n] = 1'b1; n = 2 * n; end
            else begin m_node[s][n] = 1'b0; lo = lo + size; n = 2 * n + 1; end
        end
    endtask

    task automatic m_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_node[s][w]  = 1'b0;
            end
        m_busy = 1'b0; m_cnt = 0; p_hit = 1'b0; p_idx = 0; p_way = 0;
    endtask

    // One clock: predict, advance the model, clock the DUT, compare.
    task automatic tick();
        bit              acc;
        bit              e_hit;
        bit              e_perr;
        bit              fill_same;
        logic [WAYS-1:0] e_way;
        logic [WAYS-1:0] e_vic;
        int              first;
        int              lw;
        acc = lk_val && !m_busy;
        e_hit = 1'b0; e_perr = 1'b0; e_way = '0; e_vic = '0; first = -1;
        if (acc) begin
            for (int w = 0; w < WAYS; w++) begin
                if (m_valid[lk_idx][w] && m_bad[lk_idx][w]) e_perr = 1'b1;
                else if (m_valid[lk_idx][w] && m_tag[lk_idx][w] == lk_tag) begin
                    e_way[w] = 1'b1;
                    if (first < 0) first = w;
                end
            end
            e_hit = (first >= 0);
            e_vic[m_victim(int'(lk_idx))] = 1'b1;
        end
        fill_same = !m_busy && wr_val && wr_vld && (wr_way != '0) && (int'(wr_idx) == p_idx);
        if (p_hit && !fill_same) m_touch(p_idx, p_way);
        if (!m_busy) begin
            if (wr_val) begin
                lw = -1;
                for (int w = 0; w < WAYS; w++) begin
                    if (wr_way[w]) begin
                        m_valid[wr_idx][w] = wr_vld;
                        m_bad[wr_idx][w]   = 1'b0;
                        if (wr_vld) m_tag[wr_idx][w] = wr_tag;
                        if (lw < 0) lw = w;
                    end
                end
                if (wr_vld && lw >= 0) m_touch(int'(wr_idx), lw);
            end
            if (inv_all) begin m_busy = 1'b1; m_cnt = 0; end
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[m_cnt][w] = 1'b0;
                m_node[m_cnt][w]  = 1'b0;
            end
            m_cnt++;
            if (m_cnt == SETS) m_busy = 1'b0;
        end
        p_hit = acc && e_hit; p_idx = int'(lk_idx); p_way = first;
        @(posedge clk);
        #1;
        check("rs_val", 32'(rs_val), 32'(acc));
        if (acc) begin
            check("rs_hit", 32'(rs_hit), 32'(e_hit));
            check("rs_way", 32'(rs_way), 32'(e_way));
            check("rs_victim", 32'(rs_victim), 32'(e_vic));
        end
        check("lk_rdy", 32'(lk_rdy), 32'(!m_busy));
        check("flush_busy", 32'(flush_busy), 32'(m_busy));
`ifdef DCDIR_PARITY_EN
        check("perr", 32'(perr), 32'(e_perr));
`endif
    endtask

    task automatic idle_inputs();
        lk_val = 1'b0; wr_val = 1'b0; inv_all = 1'b0; wr_vld = 1'b0; wr_way = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_clear();
        check("rst_rs_val", 32'(rs_val), 32'd0);
        check("rst_rs_hit", 32'(rs_hit), 32'd0);
        check("rst_rs_way", 32'(rs_way), 32'd0);
        check("rst_rs_victim", 32'(rs_victim), 32'd0);
        check("rst_flush_busy", 32'(flush_busy), 32'd0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_lookup(input int idx, input logic [TAG_W-1:0] tag);
        idle_inputs();
        lk_val = 1'b1; lk_idx = IDX_W'(idx); lk_tag = tag;
        tick();
        idle_inputs();
    endtask

    task automatic do_write(input int idx, input logic [WAYS-1:0] way,
                            input logic [TAG_W-1:0] tag, input bit vld);
        idle_inputs();
        wr_val = 1'b1; wr_idx = IDX_W'(idx); wr_way = way; wr_tag = tag; wr_vld = vld;
        tick();
        idle_inputs();
    endtask

    logic [TAG_W-1:0] pool [4] = '{22'h12345, 22'h00ABC, 22'h3F00F, 22'h155AA};

    initial begin
        int busy_cycles;
        int guard;
        int r;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin m_bad[s][w] = 1'b0; m_tag[s][w] = '0; end
        m_clear();

        // Reset and empty lookup
        do_reset();
        do_lookup(5, 22'h12345);
        check("tp1_hit", 32'(rs_hit), 32'd0);
        check("tp1_victim", 32'(rs_victim), 32'b0001);

        // Fill way2 and hit it
        do_write(5, 4'b0100, 22'h12345, 1'b1);
        do_lookup(5, 22'h12345);
        check("tp2_hit", 32'(rs_hit), 32'd1);
        check("tp2_way", 32'(rs_way), 32'b0100);
        tick();
        do_lookup(5, 22'h00001);
        check("tp2_victim", 32'(rs_victim), 32'b0001);

        // Tree-PLRU after filling 0..3 and hitting way0
        do_write(9, 4'b0001, pool[0], 1'b1);
        do_write(9, 4'b0010, pool[1], 1'b1);
        do_write(9, 4'b0100, pool[2], 1'b1);
        do_write(9, 4'b1000, pool[3], 1'b1);
        do_lookup(9, pool[0]);
        check("tp3_way", 32'(rs_way), 32'b0001);
        tick();
        do_lookup(9, 22'h00002);
        check("tp3_victim", 32'(rs_victim), 32'b0100);

        // Invalidate way1 of idx9 -> lowest invalid way becomes victim
        do_write(9, 4'b0010, 22'h0, 1'b0);
        do_lookup(9, pool[1]);
        check("inv_hit", 32'(rs_hit), 32'd0);
        check("inv_victim", 32'(rs_victim), 32'b0010);

        // Sweep: exactly SETS busy cycles, writes and lookups dropped
        do_write(3, 4'b0010, 22'h0BEEF, 1'b1);
        idle_inputs(); inv_all = 1'b1; tick(); idle_inputs();
        busy_cycles = 0; guard = 0;
        while (flush_busy && guard < 300) begin
            if (guard == 50) begin
                wr_val = 1'b1; wr_idx = IDX_W'(20); wr_way = 4'b0001;
                wr_tag = 22'h00077; wr_vld = 1'b1;
            end
            if (guard == 60) begin lk_val = 1'b1; lk_idx = IDX_W'(3); lk_tag = 22'h0BEEF; end
            if (guard == 70) inv_all = 1'b1;
            busy_cycles++; guard++;
            tick();
            idle_inputs();
        end
        check("flush_len", 32'(busy_cycles), 32'(SETS));
        do_lookup(3, 22'h0BEEF);
        check("flush_hit3", 32'(rs_hit), 32'd0);
        do_lookup(20, 22'h00077);
        check("flush_drop_wr", 32'(rs_hit), 32'd0);

        // Same-cycle lookup and fill: no bypass
        idle_inputs();
        lk_val = 1'b1; lk_idx = IDX_W'(7); lk_tag = 22'h00ABC;
        wr_val = 1'b1; wr_idx = IDX_W'(7); wr_way = 4'b0001; wr_tag = 22'h00ABC; wr_vld = 1'b1;
        tick();
        idle_inputs();
        check("same_cyc_hit", 32'(rs_hit), 32'd0);
        do_lookup(7, 22'h00ABC);
        check("same_cyc_next", 32'(rs_hit), 32'd1);

        // Reset in the middle of a sweep
        do_write(1, 4'b1000, 22'h00055, 1'b1);
        idle_inputs(); inv_all = 1'b1; tick(); idle_inputs();
        repeat (10) tick();
        do_reset();
        do_lookup(1, 22'h00055);
        check("midflush_rst_hit", 32'(rs_hit), 32'd0);
        check("midflush_rst_vic", 32'(rs_victim), 32'b0001);

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            idle_inputs();
            r = $urandom_range(0, 99);
            if (r < 60) begin
                lk_val = 1'b1;
                lk_idx = ($urandom_range(0, 9) == 0) ? IDX_W'($urandom_range(0, SETS - 1))
                                                     : IDX_W'($urandom_range(0, 3));
                lk_tag = pool[$urandom_range(0, 3)];
            end
            if (r >= 35) begin
                wr_val = 1'b1;
                wr_idx = IDX_W'($urandom_range(0, 3));
                wr_tag = pool[$urandom_range(0, 3)];
                wr_vld = ($urandom_range(0, 4) != 0);
                case ($urandom_range(0, 9))
                    0:       wr_way = '0;
                    1:       wr_way = WAYS'($urandom_range(0, 15));
                    default: wr_way = WAYS'(1) << $urandom_range(0, WAYS - 1);
                endcase
            end
            if ($urandom_range(0, 599) == 0) inv_all = 1'b1;
            tick();
        end
        idle_inputs();

`ifdef DCDIR_PARITY_EN
        // Corrupt stored parity of idx2 way0
        do_write(2, 4'b0001, 22'h2A2A2, 1'b1);
        dut.r_par[2][0] = ~dut.r_par[2][0];
        m_bad[2][0] = 1'b1;
        do_lookup(2, 22'h2A2A2);
        check("par_perr", 32'(perr), 32'd1);
        check("par_hit", 32'(rs_hit), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
